// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the queue-RAM controller.
package fifo_pkg;
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_e;

  localparam int FIFO_ADDR_WIDTH  = 4;
  localparam int FIFO_ALMOST_FULL = 12;
endpackage

// File: rtl/fifo_ctrl_if.sv
// Request, RAM-control and status bundle between producer/consumer logic and fifo_ctrl.
// Optional sticky error flags appear when FIFO_ERR_FLAGS_EN is defined.
interface fifo_ctrl_if import fifo_pkg::*; #(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) ();
  logic                  wr;
  logic                  rd;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  rd_valid;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport master (
    output wr, rd,
    input  wr_en, rd_en, w_addr, r_addr, full, empty, almost_full, count, rd_valid
`ifdef FIFO_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  wr, rd,
    output wr_en, rd_en, w_addr, r_addr, full, empty, almost_full, count, rd_valid
`ifdef FIFO_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/fifo_ptr.sv
// Wrap counter used for the queue read and write pointers; MSB is the wrap bit.
module fifo_ptr import fifo_pkg::*; #(
  parameter int WIDTH = FIFO_ADDR_WIDTH + 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_ptr
);
  logic [WIDTH-1:0] r_ptr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + WIDTH'(1);
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/fifo_ctrl.sv
// Control unit for the 16x8 dual-port queue RAM: acceptance, pointers, occupancy and flags.
// Sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
//
//   state   | meaning
//   EMPTY   | occupancy == 0, reads rejected
//   PARTIAL | 0 < occupancy < depth
//   FULL    | occupancy == depth, writes rejected
module fifo_ctrl import fifo_pkg::*; #(
  parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int ALMOST_FULL = FIFO_ALMOST_FULL
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  fifo_ctrl_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH  = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(ALMOST_FULL);
  localparam logic [ADDR_WIDTH:0] ONE    = (ADDR_WIDTH+1)'(1);

  fifo_state_e         r_state, w_state_nxt;
  logic [ADDR_WIDTH:0] w_wptr, w_rptr, w_count, w_count_nxt;
  logic                w_full, w_empty, w_wr_en, w_rd_en;
  logic                r_almost_full, r_rd_valid;

  // Flags come from the registered state, so acceptance never depends on this cycle's requests.
  assign w_full  = (r_state == FULL);
  assign w_empty = (r_state == EMPTY);
  assign w_wr_en = bus.wr & ~w_full;
  assign w_rd_en = bus.rd & ~w_empty;

  fifo_ptr #(.WIDTH(ADDR_WIDTH+1)) u_wptr (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (w_wr_en),
    .o_ptr     (w_wptr)
  );

  fifo_ptr #(.WIDTH(ADDR_WIDTH+1)) u_rptr (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (w_rd_en),
    .o_ptr     (w_rptr)
  );

  // Wrap bits make the modulo difference span 0..depth without ambiguity.
  assign w_count = w_wptr - w_rptr;

  always_comb begin
    w_count_nxt = w_count;
    if (w_wr_en && !w_rd_en)      w_count_nxt = w_count + ONE;
    else if (w_rd_en && !w_wr_en) w_count_nxt = w_count - ONE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= EMPTY;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_wr_en) w_state_nxt = PARTIAL;
      PARTIAL: begin
        if (w_wr_en && !w_rd_en && (w_count == DEPTH - ONE))
          w_state_nxt = FULL;
        else if (w_rd_en && !w_wr_en && (w_count == ONE))
          w_state_nxt = EMPTY;
      end
      FULL:    if (w_rd_en) w_state_nxt = PARTIAL;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_almost_full <= 1'b0;
      r_rd_valid    <= 1'b0;
    end else begin
      r_almost_full <= (w_count_nxt >= AF_LVL);
      r_rd_valid    <= w_rd_en;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow, r_underflow;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr && w_full)  r_overflow  <= 1'b1;
      if (bus.rd && w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif

  assign bus.wr_en       = w_wr_en;
  assign bus.rd_en       = w_rd_en;
  assign bus.w_addr      = w_wptr[ADDR_WIDTH-1:0];
  assign bus.r_addr      = w_rptr[ADDR_WIDTH-1:0];
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almost_full = r_almost_full;
  assign bus.count       = w_count;
  assign bus.rd_valid    = r_rd_valid;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized bench for fifo_ctrl against a queue-based occupancy/data model and a behavioural RAM.
module tb_fifo_ctrl;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] mem [DEPTH];
  logic [7:0] ram_rdata = 8'd0;

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  int q[$];
  int wcnt = 0;
  int rcnt = 0;
  int exp_rv = 0;
  int exp_rdata = 0;
  int exp_ovf = 0;
  int exp_unf = 0;

  fifo_ctrl_if bus ();

  fifo_ctrl dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  // 16x8 RAM with registered read data
  always @(posedge clk) begin
    if (bus.wr_en) mem[bus.w_addr] <= wdata;
    if (bus.rd_en) ram_rdata <= mem[bus.r_addr];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_status();
    chk("count", int'(bus.count), q.size());
    chk("full", int'(bus.full), int'(q.size() == DEPTH));
    chk("empty", int'(bus.empty), int'(q.size() == 0));
    chk("almost_full", int'(bus.almost_full), int'(q.size() >= AF));
    chk("rd_valid", int'(bus.rd_valid), exp_rv);
    if (exp_rv != 0) chk("r_data", int'(ram_rdata), exp_rdata);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow", int'(bus.overflow), exp_ovf);
    chk("underflow", int'(bus.underflow), exp_unf);
`endif
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    int acc_w, acc_r;
    check_status();
    bus.wr = w;
    bus.rd = r;
    wdata  = d;
    #1;
    acc_w = int'(w && (q.size() != DEPTH));
    acc_r = int'(r && (q.size() != 0));
    chk("wr_en", int'(bus.wr_en), acc_w);
    chk("rd_en", int'(bus.rd_en), acc_r);
    chk("w_addr", int'(bus.w_addr), wcnt % DEPTH);
    chk("r_addr", int'(bus.r_addr), rcnt % DEPTH);
    if (w && q.size() == DEPTH) exp_ovf = 1;
    if (r && q.size() == 0)     exp_unf = 1;
    if (acc_r != 0) begin
      exp_rdata = q.pop_front();
      rcnt++;
    end
    if (acc_w != 0) begin
      q.push_back(int'(d));
      wcnt++;
    end
    exp_rv = acc_r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_count", int'(bus.count), 0);
    reset_n = 1'b1;

    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);

    // fill plus one rejected write
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b0, 8'(255 - i));
    // drain plus one rejected read
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 8'd0);

    // simultaneous at empty: only the write is taken
    step(1'b1, 1'b1, 8'h5a);
    while (q.size() < 5) step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom));

    // simultaneous at full: only the read is taken
    while (q.size() < DEPTH) step(1'b1, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, 8'($urandom));
    step(1'b0, 1'b0, 8'd0);

    // random traffic with shifting bias
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i / 100) % 2 == 0 ? 70 : 30;
      step(logic'($urandom_range(0, 99) < bias), logic'($urandom_range(0, 99) < 100 - bias),
           8'($urandom));
    end

    // mid-run async reset at count 7
    while (q.size() < 7) step(1'b1, 1'b0, 8'($urandom));
    while (q.size() > 7) step(1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b1, 8'd0);
    step(1'b1, 1'b0, 8'($urandom));
    chk("pre_rst_count", int'(bus.count), 7);
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_empty", int'(bus.empty), 1);
    chk("arst_full", int'(bus.full), 0);
    chk("arst_count", int'(bus.count), 0);
    chk("arst_w_addr", int'(bus.w_addr), 0);
    chk("arst_r_addr", int'(bus.r_addr), 0);
    chk("arst_rd_valid", int'(bus.rd_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    wcnt = 0;
    rcnt = 0;
    exp_rv = 0;
    exp_ovf = 0;
    exp_unf = 0;

    step(1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 60; i++)
      step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 8'($urandom));
    check_status();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control unit for the 16x8 dual-port queue RAM. Accepts write and read requests from producer and consumer logic. Drives the RAM's write/read enables and addresses, and tracks occupancy. Produces full, empty, almost-full, count and a read-data-valid strobe aligned with the RAM's registered r_data.

## Interface
Parameters:
- ADDR_WIDTH, 4: RAM address width; depth = 2**ADDR_WIDTH (16).
- ALMOST_FULL, 12: occupancy at or above which almost_full asserts; legal range 1..depth.

Ports:
- clk  in  1: single clock; all state on posedge.
- reset_n  in  1: asynchronous, active-low reset.
- wr  in  1: producer write request, one entry per cycle.
- rd  in  1: consumer read request, one entry per cycle.
- wr_en  out  1: RAM write enable (accepted write).
- rd_en  out  1: RAM read enable (accepted read).
- w_addr  out  ADDR_WIDTH: RAM write address.
- r_addr  out  ADDR_WIDTH: RAM read address.
- full  out  1: occupancy == depth.
- empty  out  1: occupancy == 0.
- almost_full  out  1: occupancy >= ALMOST_FULL.
- count  out  ADDR_WIDTH+1: occupancy, 0..depth.
- rd_valid  out  1: RAM r_data holds the entry popped in the previous cycle.
- overflow  out  1: sticky; present only with FIFO_ERR_FLAGS_EN.
- underflow  out  1: sticky; present only with FIFO_ERR_FLAGS_EN.

## Operation
- Pointers:
  - wptr and rptr are ADDR_WIDTH+1 bits.
  - w_addr = wptr[ADDR_WIDTH-1:0]; r_addr = rptr[ADDR_WIDTH-1:0].
  - The MSB is a wrap bit; increment is modulo 2**(ADDR_WIDTH+1).
- Acceptance is combinational from current state: wr_en = wr & ~full; rd_en = rd & ~empty.
- Simultaneous requests:
  - When full, the write is rejected even if a read is accepted the same cycle.
  - When empty, the read is rejected even if a write is accepted the same cycle.
  - No bypass path.
- On posedge:
  - wptr increments if wr_en; rptr increments if rd_en.
  - count += wr_en − rd_en; both accepted leaves count unchanged.
- State register (fifo_state_e):
  - EMPTY: count==0.
  - PARTIAL: 0<count<depth.
  - FULL: count==depth.
  - EMPTY→PARTIAL on an accepted write only.
  - PARTIAL→FULL when count==depth−1 and write-only.
  - PARTIAL→EMPTY when count==1 and read-only.
  - FULL→PARTIAL on an accepted read.
  - full/empty decode from state, registered — no combinational path from wr/rd.
- almost_full is registered from the next-count value.
- rd_valid <= rd_en, one cycle after acceptance, matching the RAM read latency.

## Timing
- Reset values (asynchronous, while reset_n low):
  - wptr=rptr=0, count=0, state=EMPTY.
  - empty=1, full=0, almost_full=0, rd_valid=0, overflow=underflow=0.
- Reset mid-operation discards all entries; RAM contents are not cleared. The first cycle after deassertion behaves as empty.
- wr_en/rd_en/w_addr/r_addr are valid in the request cycle. The RAM captures them on the same edge the controller updates its pointers.
- Read latency: rd asserted in cycle N with empty=0 → rd_valid=1 in N+1, with r_data from address r_addr(N).
- Flag latency: full/empty/count/almost_full reflect all accepted operations one cycle after the edge.
- Wrap: after 16 writes from reset, wptr=5'b10000, w_addr=0. full=1 while rptr=5'b00000.

## Configuration
- FIFO_ERR_FLAGS_EN defined:
  - overflow sets on wr & full; underflow sets on rd & empty.
  - Both stay set until reset.
- FIFO_ERR_FLAGS_EN undefined: the overflow/underflow ports and their logic are absent. Rejected requests are silently dropped.

## Structure
- fifo_pkg holds typedef enum logic [1:0] fifo_state_e {EMPTY, PARTIAL, FULL} and default constants FIFO_ADDR_WIDTH=4, FIFO_ALMOST_FULL=12.
- Sub-module fifo_ptr: an (ADDR_WIDTH+1)-bit wrap counter with async active-low reset and an increment enable. fifo_ctrl instantiates it twice (write and read).
- Integration top instantiates fifo_ctrl beside the 2-port RAM; not part of this block.

## Test plan
- Reset: reset_n low mid-run with count=7 → empty=1, count=0, w_addr=r_addr=0, rd_valid=0, immediately (async).
- Fill: 16 consecutive wr with no rd → count 1..16; almost_full rises after the 12th write; full=1 after the 16th; w_addr sequence 0..15 then 0.
- Overflow: 17th wr while full → wr_en=0, count stays 16; overflow=1 (macro defined) and remains set.
- Drain: 16 rd, data written as 255−i → rd_valid high each following cycle, r_data 255..240 in order; empty=1 after the last read; a further rd gives rd_en=0 and underflow=1.
- Simultaneous: at count=5, wr&rd for 20 cycles → count stays 5, both pointers advance 20 and wrap, data order preserved. At count=0, wr&rd → only the write is accepted, count=1.
- Full + read: at count=16, wr&rd → rd_en=1, wr_en=0; next cycle count=15, state PARTIAL.
